// File: rtl/ledmon_pkg.sv
// Shared types for the LED pattern monitor: default widths, FSM states and
// the record layout {pattern, dwell} at default widths.
package ledmon_pkg;

    localparam int LEDMON_W     = 8;
    localparam int LEDMON_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ledmon_state_t;

    typedef struct packed {
        logic [LEDMON_W-1:0]     pattern;
        logic [LEDMON_CNT_W-1:0] dwell;
    } ledmon_rec_t;

endpackage

// File: rtl/ledmon_fifo.sv
// Record FIFO for the LED pattern monitor. DEPTH entries (power of 2), extra
// pointer MSB separates full from empty. A push into a full FIFO succeeds only
// when a pop happens on the same edge; otherwise it is ignored here and the
// caller flags the drop.
module ledmon_fifo #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_pattern,
    input  logic [CNT_W-1:0] push_dwell,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [W-1:0]     head_pattern,
    output logic [CNT_W-1:0] head_dwell
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_pattern [DEPTH];
    logic [CNT_W-1:0] mem_dwell   [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so outputs read 0 out of reset.
    assign head_pattern = empty ? '0 : mem_pattern[rd_ptr[AW-1:0]];
    assign head_dwell   = empty ? '0 : mem_dwell[rd_ptr[AW-1:0]];

    // Pointer update; wraps modulo DEPTH through the natural AW+1 bit rollover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Record storage; no reset needed since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pattern[wr_ptr[AW-1:0]] <= push_pattern;
            mem_dwell[wr_ptr[AW-1:0]]   <= push_dwell;
        end
    end

endmodule

// File: rtl/led_pattern_monitor.sv
// LED pattern monitor: samples the pattern bus while armed and records each
// distinct pattern with its dwell time (clock edges) into a record FIFO that
// is drained over a valid/ready port.
// Optional stall detection is built when LEDMON_STALL_DETECT_EN is defined.
module led_pattern_monitor
    import ledmon_pkg::*;
#(
    parameter int W       = LEDMON_W,
    parameter int CNT_W   = LEDMON_CNT_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     pin,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [W-1:0]     rd_pattern,
    output logic [CNT_W-1:0] rd_dwell,
    output logic             busy,
    output logic             overflow,
    output logic             stall
);

    ledmon_state_t    state, state_nxt;
    logic [W-1:0]     cur, cur_nxt;
    logic [CNT_W-1:0] dwell, dwell_nxt;
    logic             push;
    logic             latch;
    logic             changed;
    logic             hold;
    logic             full;
    logic             empty;
    logic             pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign busy     = (state == RUN);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;

    // Next-state, change detect and dwell counting; stop outranks start.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        dwell_nxt = dwell;
        push      = 1'b0;
        latch     = 1'b0;
        changed   = 1'b0;
        hold      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    latch     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else if (start) begin
                    latch = 1'b1;
                end else if (pin != cur) begin
                    push    = 1'b1;
                    changed = 1'b1;
                end else begin
                    hold      = 1'b1;
                    dwell_nxt = sat_inc(dwell);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (latch || changed) begin
            cur_nxt   = pin;
            dwell_nxt = CNT_W'(1);
        end
    end

    // FSM, current pattern and dwell registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cur   <= '0;
            dwell <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            dwell <= dwell_nxt;
        end
    end

    // Sticky drop flag, cleared whenever capture is (re)armed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (latch) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef LEDMON_STALL_DETECT_EN
    logic stall_r;

    // Stall rises when the held pattern's dwell reaches TIMEOUT; stop keeps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= 1'b0;
        end else if (latch || changed) begin
            stall_r <= 1'b0;
        end else if (hold && (dwell_nxt == CNT_W'(TIMEOUT))) begin
            stall_r <= 1'b1;
        end
    end

    assign stall = stall_r;
`else
    logic unused_stall_cfg;

    // Without stall detection the hold strobe and TIMEOUT have no consumer.
    assign unused_stall_cfg = hold ^ (TIMEOUT != 0);
    assign stall            = 1'b0;
`endif

    ledmon_fifo #(
        .W     (W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_pattern (cur),
        .push_dwell   (dwell),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .head_pattern (rd_pattern),
        .head_dwell   (rd_dwell)
    );

endmodule

// File: doc/led_pattern_monitor.md
# led_pattern_monitor

Receive-side companion to the LED blinker. It samples the 8-bit LED pattern bus and records each distinct pattern with its dwell time in clock cycles. Records are buffered in a small FIFO and drained over a valid/ready read port. It serves as the on-chip observer for blinker sequences and as the self-check block in blinker benches.

## Interface
- `W`, 8: pattern bus width.
- `CNT_W`, 16: dwell counter width.
- `DEPTH`, 4: record FIFO depth; must be a power of 2 and at least 2.
- `TIMEOUT`, 1000: stall threshold in cycles; only used with `LEDMON_STALL_DETECT_EN`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Asserted when 0.
- `start`, in, 1: arms capture, or restarts it when already capturing.
- `stop`, in, 1: ends capture and flushes the partial record.
- `pin`, in, W: observed pattern. Must come from the `clk` domain; no synchronizer is provided.
- `rd_valid`, out, 1: FIFO head record is available.
- `rd_ready`, in, 1: consumer accepts the head record.
- `rd_pattern`, out, W: pattern field of the head record.
- `rd_dwell`, out, CNT_W: dwell field of the head record.
- `busy`, out, 1: high while in RUN.
- `overflow`, out, 1: sticky; at least one record was dropped.
- `stall`, out, 1: pattern has been unchanged for at least `TIMEOUT` cycles.

## Operation
- FSM states:
  - IDLE: `pin` is ignored.
  - RUN: capturing.
- IDLE to RUN, on an edge with `start`=1 and `stop`=0:
  - latch `cur`<=`pin`, `dwell`<=1.
  - clear `overflow` and `stall`.
- RUN, `pin`==`cur`: `dwell`<=`dwell`+1, saturating at 2^CNT_W−1.
- RUN, `pin`!=`cur`:
  - push record {`cur`,`dwell`}.
  - `cur`<=`pin`, `dwell`<=1.
- RUN with `stop`=1: push {`cur`,`dwell`}; the sampled `pin` is not counted. Go to IDLE.
- RUN with `start`=1 and `stop`=0:
  - discard the partial record; nothing is pushed.
  - re-latch `cur`<=`pin`, `dwell`<=1.
  - clear `overflow` and `stall`. FIFO contents are kept.
- `stop` has priority over `start` in every state. `stop` in IDLE has no effect.
- Push while the FIFO is full and no pop happens on the same edge: the record is dropped and `overflow`<=1.
- Pop: when `rd_valid`&&`rd_ready`, the FIFO advances.
- Push and pop on the same edge: both take effect, including when full. Nothing is dropped and the count is unchanged.
- `rd_pattern`/`rd_dwell` are stable while `rd_valid`=1 and `rd_ready`=0. They are don't-care when `rd_valid`=0.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`=0, `rd_valid`=0, `overflow`=0, `stall`=0.
  - `rd_pattern`=0, `rd_dwell`=0.
  - FIFO pointers = 0, `cur`=0, `dwell`=0.
- Reset mid-RUN clears all state immediately; FIFO contents are lost.
- Push latency: a change sampled at edge k (or `stop` at edge k) gives `rd_valid`=1 after edge k, i.e. in cycle k+1.
- Dwell semantics: the number of rising edges at which `cur` was sampled in RUN, counting from the latch edge.
- `busy` rises after the `start` edge and falls after the `stop` edge.
- Pointers wrap modulo `DEPTH`. Full/empty is decided by an extra pointer MSB.
- Throughput: one push and one pop per cycle.

## Configuration
- `LEDMON_STALL_DETECT_EN` defined:
  - in RUN, `stall`<=1 on the edge where `dwell` reaches `TIMEOUT`.
  - `stall` stays high until the next pattern change, `start`, or reset.
  - `stop` leaves `stall` unchanged.
- Not defined: `stall` is tied to 0, no comparator is built, and `TIMEOUT` is ignored. The port list is identical in both builds.

## Structure
- `ledmon_pkg` holds:
  - default `W`/`CNT_W`.
  - the FSM state enum {IDLE, RUN}.
  - the record struct {pattern, dwell}.
- Sub-module `ledmon_fifo`:
  - synchronous FIFO of records: `DEPTH` entries, push/pop/full/empty.
  - instantiated once.
- Top level holds the FSM, change detect, dwell counter and flags.

## Test plan
- Basic record:
  - stimulus: `start` pulse, then `pin`=0x01 for 5 edges, then 0x02; `rd_ready`=1.
  - response: one record {0x01,5}, with `rd_valid` in the cycle after the 0x02 edge.
- Blinker loopback:
  - stimulus: blinker drives `pin`, 20 ns clock, `start` held for 1 cycle.
  - response: every record's dwell equals the blinker step period; patterns follow the blinker sequence.
- Overflow:
  - stimulus: `DEPTH`=4, `rd_ready`=0, 6 pattern changes.
  - response: 4 records held, `overflow`=1, first 4 patterns in order.
  - follow-up: drain with `rd_ready`=1, then pulse `start`; `overflow`=0.
- Full with simultaneous push/pop:
  - stimulus: FIFO full, `rd_ready`=1 on the same edge as a change.
  - response: no drop, `overflow` stays 0, FIFO count stays 4.
- Stop/start priority and restart:
  - `start`=`stop`=1 in RUN: one record is pushed and the FSM goes to IDLE.
  - `start` alone mid-pattern: no push, dwell restarts at 1.
- Stall, with macro and `TIMEOUT`=10:
  - `pin` constant: `stall`=1 after the 10th counted edge.
  - change of `pin`: `stall`=0 after the next edge.
  - without the macro: `stall` is always 0.
- Reset mid-RUN:
  - stimulus: `rst`=0 asynchronously with 2 records queued.
  - response: `rd_valid`, `busy` and `overflow` all go to 0 immediately, without waiting for a clock edge.
